if_fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one instruction-memory request at a time.
- Drives the fetched instruction and its PC to the IF/ID register with a valid flag.
- Honours hazard-unit stalls (pc_write) and EX-stage branch/jump redirects, discarding any in-flight response made stale by a redirect.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_perf_cnt.sv | 22 ++
 rtl/if_fetch_stage.sv | 123 ++++++++++++
 tb/tb_if_fetch_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding and default PC/NOP values.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch/drop event counters for the fetch stage; 1-cycle update, wrap at 2^32.
// No backpressure: counts every event pulse it sees.
module if_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_evt,
  input  logic        drop_evt,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'h0;
      drop_cnt  <= 32'h0;
    end else begin
      if (fetch_evt) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop_evt)  drop_cnt  <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// PC owner and single-outstanding fetch engine; fetch-to-valid >= 2 cycles.
// Stalls in HOLD while pc_write=0; optional counters under IF_FETCH_CNT_EN.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        if_valid
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         rst_hold_q;
  logic         issue;

  // The cycle right after reset keeps FETCH idle so the first request
  // lands one cycle after reset deasserts, with no path from reset to im_req.
  assign issue   = (state_q == FETCH) && !rst_hold_q;
  assign im_req  = issue;
  assign im_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    case (state_q)
      FETCH: begin
        if (issue) state_d = redirect_valid ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = im_rvalid ? FETCH : DRAIN;
        end else if (im_rvalid) begin
          instr_d  = im_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = FETCH;
        end else if (pc_write) begin
          pc_d    = pc_q + PC_STEP;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (im_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Redirect overrides whatever the state logic chose for the PC.
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_out_q   <= RESET_PC;
      valid_q    <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      rst_hold_q <= 1'b0;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_out_q;
  assign if_valid    = valid_q;

`ifdef IF_FETCH_CNT_EN
  logic fetch_evt;
  logic drop_evt;

  assign fetch_evt = (state_q == HOLD) && pc_write && !redirect_valid;
  assign drop_evt  = im_rvalid &&
                     ((state_q == DRAIN) || ((state_q == WAIT) && redirect_valid));

  if_perf_cnt u_perf_cnt (
    .clk       (clk),
    .reset     (reset),
    .fetch_evt (fetch_evt),
    .drop_evt  (drop_evt),
    .fetch_cnt (fetch_cnt),
    .drop_cnt  (drop_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency memory responder.
// Counter checks are compiled in when IF_FETCH_CNT_EN is defined.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_write = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        if_valid;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int lat   = 1;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_rvalid      (im_rvalid),
    .im_rdata       (im_rdata),
    .instruction    (instruction),
    .pc             (pc),
    .if_valid       (if_valid)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h00A0_0093 : (a ^ 32'h1300_0000);
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Memory answers `lat` cycles after the request cycle, returning mem_word(addr).
  initial begin : mem_model
    int          cnt;
    logic [31:0] addr;
    cnt  = 0;
    addr = 32'h0;
    forever begin
      @(negedge clk);
      im_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = mem_word(addr);
        end
      end
      if (im_req === 1'b1) begin
        cnt  = lat;
        addr = im_addr;
      end
    end
  end

  task automatic fetch_one(input logic [31:0] a, input int stall);
    tick;
    expect_eq("fetch_req", 32'(im_req), 32'd1);
    expect_eq("fetch_addr", im_addr, a);
    tick;
    expect_eq("wait_req", 32'(im_req), 32'd0);
    expect_eq("wait_vld", 32'(if_valid), 32'd0);
    if (stall > 0) pc_write = 1'b0;
    tick;
    expect_eq("hold_vld", 32'(if_valid), 32'd1);
    expect_eq("hold_pc", pc, a);
    expect_eq("hold_instr", instruction, mem_word(a));
    for (int s = 0; s < stall; s++) begin
      tick;
      expect_eq("stall_vld", 32'(if_valid), 32'd1);
      expect_eq("stall_pc", pc, a);
      expect_eq("stall_instr", instruction, mem_word(a));
      expect_eq("stall_req", 32'(im_req), 32'd0);
    end
    pc_write = 1'b1;
  endtask

  initial begin
    tick;
    expect_eq("rst_req", 32'(im_req), 32'd0);
    expect_eq("rst_addr", im_addr, 32'h0);
    expect_eq("rst_instr", instruction, 32'h0);
    expect_eq("rst_pc", pc, 32'h0);
    expect_eq("rst_vld", 32'(if_valid), 32'd0);
    tick;
    reset = 1'b0;

    // Sequential fetch with 1-cycle memory; pc 0x4 held for 5 stall cycles.
    fetch_one(32'h0, 0);
    fetch_one(32'h4, 5);
    fetch_one(32'h8, 0);
    fetch_one(32'hC, 0);

    // Redirect during WAIT with 3-cycle memory.
    lat = 3;
    tick;
    expect_eq("r3_req", 32'(im_req), 32'd1);
    expect_eq("r3_addr", im_addr, 32'h10);
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick;
    redirect_valid = 1'b0;
    expect_eq("r3_drain_req", 32'(im_req), 32'd0);
    expect_eq("r3_drain_vld", 32'(if_valid), 32'd0);
    tick;
    expect_eq("r3_drain2_req", 32'(im_req), 32'd0);
    expect_eq("r3_drain2_vld", 32'(if_valid), 32'd0);
    tick;
    expect_eq("r3_new_req", 32'(im_req), 32'd1);
    expect_eq("r3_new_addr", im_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_eq("r3_wait_vld", 32'(if_valid), 32'd0);
      expect_eq("r3_wait_req", 32'(im_req), 32'd0);
    end
    tick;
    expect_eq("r3_hold_vld", 32'(if_valid), 32'd1);
    expect_eq("r3_hold_pc", pc, 32'h100);
    expect_eq("r3_hold_instr", instruction, 32'h1300_0100);
    lat = 1;

    // Redirect coinciding with the response in WAIT.
    tick;
    expect_eq("rw_addr", im_addr, 32'h104);
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick;
    redirect_valid = 1'b0;
    expect_eq("rw_req", 32'(im_req), 32'd1);
    expect_eq("rw_addr2", im_addr, 32'h200);
    expect_eq("rw_vld", 32'(if_valid), 32'd0);
`ifdef IF_FETCH_CNT_EN
    // Two drops so far: the stale 0x10 response and the 0x104 one.
    expect_eq("rw_drop_cnt", drop_cnt, 32'd2);
    expect_eq("rw_fetch_cnt", fetch_cnt, 32'd5);
`endif
    tick;
    tick;
    expect_eq("rw_hold_pc", pc, 32'h200);

    // Redirect and pc_write together in HOLD: redirect wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick;
    redirect_valid = 1'b0;
    expect_eq("rh_req", 32'(im_req), 32'd1);
    expect_eq("rh_addr", im_addr, 32'h40);
    expect_eq("rh_vld", 32'(if_valid), 32'd0);
`ifdef IF_FETCH_CNT_EN
    expect_eq("rh_fetch_cnt", fetch_cnt, 32'd5);
`endif
    tick;
    tick;
    expect_eq("rh_hold_pc", pc, 32'h40);

    // Low bits of the target are cleared; then PC wraps past the top.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick;
    redirect_valid = 1'b0;
    expect_eq("wrap_top_addr", im_addr, 32'hFFFF_FFFC);
    tick;
    tick;
    expect_eq("wrap_top_pc", pc, 32'hFFFF_FFFC);
    lat = 3;
    tick;
    expect_eq("wrap_req", 32'(im_req), 32'd1);
    expect_eq("wrap_addr", im_addr, 32'h0);

    // Reset while WAIT; the late response lands during reset and is ignored.
    tick;
    reset = 1'b1;
    tick;
    expect_eq("mrst_req", 32'(im_req), 32'd0);
    expect_eq("mrst_vld", 32'(if_valid), 32'd0);
    expect_eq("mrst_pc", pc, 32'h0);
`ifdef IF_FETCH_CNT_EN
    expect_eq("mrst_fetch_cnt", fetch_cnt, 32'd0);
    expect_eq("mrst_drop_cnt", drop_cnt, 32'd0);
`endif
    tick;
    reset = 1'b0;
    expect_eq("mrst_req2", 32'(im_req), 32'd0);
    tick;
    expect_eq("post_req", 32'(im_req), 32'd1);
    expect_eq("post_addr", im_addr, 32'h0);
    expect_eq("post_vld", 32'(if_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_eq("post_wait_vld", 32'(if_valid), 32'd0);
    end
    tick;
    expect_eq("post_hold_vld", 32'(if_valid), 32'd1);
    expect_eq("post_hold_pc", pc, 32'h0);
    expect_eq("post_hold_instr", instruction, 32'h1300_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
